// File: rtl/fifo_thresh_if.sv
// Bus bundle for fifo_thresh: write/read handshake, threshold inputs and status outputs.
// The master side drives requests and bounds; the slave side is the FIFO.
interface fifo_thresh_if #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 3
) ();
   logic                  push;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] low_bound;
   logic [ADDR_WIDTH-1:0] up_bound;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic                  error;
   logic [ADDR_WIDTH:0]   count;

   modport master (
      output push, data_in, pop, low_bound, up_bound,
      input  data_out, valid_out, empty, full, almost_empty, almost_full, error, count
   );

   modport slave (
      input  push, data_in, pop, low_bound, up_bound,
      output data_out, valid_out, empty, full, almost_empty, almost_full, error, count
   );
endinterface

// File: rtl/fifo_thresh.sv
// Single-clock FIFO with live almost-empty/almost-full thresholds and a registered read port.
// Define FIFO_STICKY_ERR_EN to make error latch until reset instead of pulsing for one cycle.
module fifo_thresh #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 3
) (
   input  logic          clk,
   input  logic          reset,
   fifo_thresh_if.slave  bus
);

   localparam int unsigned             DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]     DEPTH_C  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]     CNT_ZERO = {(ADDR_WIDTH + 1){1'b0}};
   localparam logic [ADDR_WIDTH:0]     CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0]   PTR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0]   PTR_ONE  = CNT_ONE[ADDR_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0]   DAT_ZERO = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_out_q, valid_out_d;
   logic                  error_q, error_d;

   logic empty_s, full_s, rd_acc_s, wr_acc_s, ovf_s, unf_s, err_evt_s;

   function automatic logic next_error(input logic prev, input logic evt);
`ifdef FIFO_STICKY_ERR_EN
      next_error = prev | evt;
`else
      next_error = evt | (prev & 1'b0);
`endif
   endfunction

   // Occupancy flags and request acceptance; a pop on a full FIFO frees the slot for a same-cycle push.
   always_comb begin
      empty_s   = (count_q == CNT_ZERO);
      full_s    = (count_q == DEPTH_C);
      rd_acc_s  = bus.pop & ~empty_s;
      wr_acc_s  = bus.push & (~full_s | rd_acc_s);
      ovf_s     = bus.push & full_s & ~rd_acc_s;
      unf_s     = bus.pop & empty_s;
      err_evt_s = ovf_s | unf_s;
   end

   // Pointer, count, read-port and error next state; reset overrides any request.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      error_d     = error_q;
      if (!reset) begin
         wr_ptr_d    = PTR_ZERO;
         rd_ptr_d    = PTR_ZERO;
         count_d     = CNT_ZERO;
         data_out_d  = DAT_ZERO;
         valid_out_d = 1'b0;
         error_d     = 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_acc_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
         end else begin
            rd_ptr_d    = rd_ptr_q;
            data_out_d  = data_out_q;
            valid_out_d = 1'b0;
         end
         case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         error_d = next_error(error_q, err_evt_s);
      end
   end

   // Storage next state: only an accepted push outside reset touches the array.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_d[i] = mem_q[i];
      end
      if (reset && wr_acc_s) begin
         mem_d[wr_ptr_q] = bus.data_in;
      end else begin
         mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
   end

   // Control and read-port registers.
   always_ff @(posedge clk) begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
   end

   // Storage array; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign bus.data_out     = data_out_q;
   assign bus.valid_out    = valid_out_q;
   assign bus.error        = error_q;
   assign bus.count        = count_q;
   assign bus.empty        = empty_s;
   assign bus.full         = full_s;
   assign bus.almost_empty = (count_q <= {1'b0, bus.low_bound});
   assign bus.almost_full  = (count_q >= {1'b0, bus.up_bound});

endmodule

// File: tb/tb_fifo_thresh.sv
// Scoreboard bench for fifo_thresh: a queue-based reference model predicts each edge's response,
// and an independent monitor compares valid_out/data_out/error after every rising edge.
module tb_fifo_thresh;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   edge_n;
   bit   started;

   logic [2:0] cur_lb;
   logic [2:0] cur_ub;

   logic [9:0] model_q [$];
   logic [9:0] last_d;
   logic       err_m;

   typedef struct {
      logic       v;
      logic [9:0] d;
      logic       e;
      int         tag;
   } exp_t;
   exp_t sb_q [$];

   fifo_thresh_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();

   fifo_thresh #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, check live flags, then predict the edge's result.
   task automatic step(input logic rst_n, input logic p, input logic [9:0] d, input logic po);
      int n;
      logic rd, wr, ev;
      @(negedge clk);
      reset         = rst_n;
      bus.push      = p;
      bus.data_in   = d;
      bus.pop       = po;
      bus.low_bound = cur_lb;
      bus.up_bound  = cur_ub;
      #1;
      n = model_q.size();
      if (started) begin
         chk("count",        16'(bus.count),        16'(n));
         chk("empty",        16'(bus.empty),        16'(n == 0));
         chk("full",         16'(bus.full),         16'(n == 8));
         chk("almost_empty", 16'(bus.almost_empty), 16'(n <= int'(cur_lb)));
         chk("almost_full",  16'(bus.almost_full),  16'(n >= int'(cur_ub)));
      end
      rd = 1'b0;
      if (!rst_n) begin
         model_q.delete();
         last_d  = 10'h000;
         err_m   = 1'b0;
         started = 1'b1;
      end else begin
         rd = po && (n > 0);
         wr = p && ((n < 8) || rd);
         ev = (p && !wr) || (po && (n == 0));
         if (rd) last_d = model_q.pop_front();
         if (wr) model_q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
         err_m = err_m | ev;
`else
         err_m = ev;
`endif
      end
      if (started) sb_q.push_back('{v: rd, d: last_d, e: err_m, tag: edge_n + 1});
   endtask

   // Monitor: after each rising edge compare the DUT's registered outputs with the predicted entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         edge_n = edge_n + 1;
         #1;
         if (sb_q.size() > 0 && sb_q[0].tag == edge_n) begin
            e = sb_q.pop_front();
            chk("valid_out", 16'(bus.valid_out), 16'(e.v));
            chk("data_out",  16'(bus.data_out),  16'(e.d));
            chk("error",     16'(bus.error),     16'(e.e));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      edge_n      = 0;
      started     = 1'b0;
      last_d      = 10'h000;
      err_m       = 1'b0;
      cur_lb      = 3'd1;
      cur_ub      = 3'd6;
      reset         = 1'b0;
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.data_in   = 10'h000;
      bus.low_bound = cur_lb;
      bus.up_bound  = cur_ub;

      step(1'b0, 1'b0, 10'h000, 1'b0);
      step(1'b1, 1'b0, 10'h000, 1'b0);
      step(1'b1, 1'b0, 10'h000, 1'b0);

      // Fill to full, then one overflowing push that must be dropped.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 10'(i), 1'b0);
      step(1'b1, 1'b1, 10'h3FF, 1'b0);
      step(1'b1, 1'b0, 10'h000, 1'b0);
      step(1'b1, 1'b0, 10'h000, 1'b0);

      // Drain, then one underflowing pop.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
      step(1'b1, 1'b0, 10'h000, 1'b0);

      // Wrap-around past the last slot.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 10'h0A0 + 10'(i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 10'h010 + 10'(i), 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10'h000, 1'b1);

      // Push+pop on full, drain, then push+pop on empty.
      cur_ub = 3'd7;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 10'h100 + 10'(i), 1'b0);
      step(1'b1, 1'b1, 10'h1AA, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h000, 1'b1);
      step(1'b1, 1'b1, 10'h2BB, 1'b1);
      step(1'b1, 1'b0, 10'h000, 1'b1);
      step(1'b1, 1'b0, 10'h000, 1'b0);

      // Reset mid-operation while pushing, then a pop that must underflow.
      cur_ub = 3'd0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 10'h050 + 10'(i), 1'b0);
      step(1'b0, 1'b1, 10'h05F, 1'b0);
      step(1'b1, 1'b0, 10'h000, 1'b1);
      step(1'b1, 1'b0, 10'h000, 1'b0);
      step(1'b1, 1'b0, 10'h000, 1'b0);

      // Randomised traffic with live threshold changes and occasional resets.
      for (int i = 0; i < 600; i++) begin
         cur_lb = 3'($urandom_range(0, 7));
         cur_ub = 3'($urandom_range(0, 7));
         step(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
              10'($urandom), 1'($urandom_range(0, 1)));
      end

      step(1'b1, 1'b0, 10'h000, 1'b0);
      step(1'b1, 1'b0, 10'h000, 1'b0);
      @(posedge clk);
      #2;
      chk("sb_drained", 16'(sb_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
